// File: rtl/chase_pkg.sv
// Shared types and helpers for the chase steering controller.
// Holds the FSM state encoding, the latched frame payload and duty saturation.
package chase_pkg;

  localparam int unsigned DUTY_W = 8;
  localparam int unsigned XF_W   = 11;
  localparam int unsigned ERR_W  = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    TRACK  = 2'd2,
    STOP   = 2'd3
  } chase_state_e;

  typedef struct packed {
    logic            valid;
    logic            near;
    logic [XF_W-1:0] x;
  } frame_sample_t;

  // Signed add clamped to the unsigned duty range 0..2**DUTY_W-1.
  function automatic logic [DUTY_W-1:0] sat_add(input logic signed [ERR_W-1:0] a,
                                                 input logic signed [ERR_W-1:0] b);
    logic signed [ERR_W:0] sum;
    sum = (ERR_W+1)'(a) + (ERR_W+1)'(b);
    if (sum[ERR_W])
      return '0;
    else if (|sum[ERR_W-1:DUTY_W])
      return '1;
    else
      return sum[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/chase_steer_motor_pwm.sv
// Single motor PWM channel: prescaler, 8-bit period counter and a duty
// value that is only picked up at the period boundary so pulses never tear.
module motor_pwm
  import chase_pkg::*;
#(
  parameter int unsigned PWM_DIV = 254
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm
);

  localparam int unsigned PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [PRE_W-1:0]  presc;
  logic [DUTY_W-1:0] pc;
  logic [DUTY_W-1:0] active_duty;
  logic              step_c;
  logic              wrap_c;

  assign step_c = (presc == PRE_W'(PWM_DIV - 1));
  assign wrap_c = step_c && (pc == '1);

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      presc       <= '0;
      pc          <= '0;
      active_duty <= '0;
      pwm         <= 1'b0;
    end else begin
      presc <= step_c ? '0 : presc + PRE_W'(1);
      if (step_c)
        pc <= pc + DUTY_W'(1);
      if (wrap_c)
        active_duty <= duty;
      pwm <= (pc < active_duty);
    end
  end

endmodule

// File: rtl/chase_steer_ctrl.sv
// Per-frame blob follower: samples tracker centroid/radius on vsync fall,
// runs search/track/stop and drives two differential motor PWM channels.
module chase_steer_ctrl
  import chase_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 1024,
  parameter int unsigned H_CENTER    = 512,
  parameter int unsigned MIN_RADIUS  = 4,
  parameter int unsigned STOP_RADIUS = 60,
  parameter int unsigned BASE_DUTY   = 128,
  parameter int unsigned SEARCH_DUTY = 80,
  parameter int unsigned KP_SHIFT    = 1,
  parameter int unsigned ALPHA_SHIFT = 1,
  parameter int unsigned LOST_FRAMES = 8,
  parameter int unsigned PWM_DIV     = 254
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        en,
  input  logic        vsync,
  input  logic [31:0] x_center,
  input  logic [23:0] radius,
  output logic        pwm_left,
  output logic        pwm_right,
  output logic        dir_left,
  output logic        dir_right,
  output logic [1:0]  state,
  output logic        frame_stb
);

  localparam int unsigned LOST_W = $clog2(LOST_FRAMES + 1);

  logic                     vsync_q;
  logic                     fall_c;
  frame_sample_t            smp;
  chase_state_e             state_q, state_d;
  logic [XF_W-1:0]          x_filt, x_filt_d;
  logic [LOST_W-1:0]        lost_cnt, lost_d;
  logic signed [ERR_W-1:0]  x_s, xf_s, diff_c, x_iir_c, err_c, adj_c, base_c;
  logic [DUTY_W-1:0]        duty_l, duty_r, duty_l_c, duty_r_c;
  logic                     dir_l_c, dir_r_c;

  assign fall_c = vsync_q & ~vsync;
  assign state  = state_q;

  // Frame edge detect and sample latch; validity is judged on full input width.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      vsync_q   <= 1'b0;
      frame_stb <= 1'b0;
      smp       <= '0;
    end else begin
      vsync_q   <= vsync;
      frame_stb <= fall_c;
      if (fall_c) begin
        smp.valid <= (radius >= 24'(MIN_RADIUS)) && (x_center < 32'(H_ACTIVE));
        smp.near  <= (radius >= 24'(STOP_RADIUS));
        smp.x     <= x_center[XF_W-1:0];
      end
    end
  end

  assign x_s     = signed'({1'b0, smp.x});
  assign xf_s    = signed'({1'b0, x_filt});
  assign diff_c  = x_s - xf_s;
  assign x_iir_c = xf_s + (diff_c >>> ALPHA_SHIFT);

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      x_filt   <= XF_W'(H_CENTER);
      lost_cnt <= '0;
    end else begin
      state_q  <= state_d;
      x_filt   <= x_filt_d;
      lost_cnt <= lost_d;
    end
  end

  // Next state; only frame strobes advance the FSM, en low overrides at once.
  always_comb begin
    state_d  = state_q;
    x_filt_d = x_filt;
    lost_d   = lost_cnt;
    if (!en) begin
      state_d = IDLE;
      lost_d  = '0;
    end else if (frame_stb) begin
      case (state_q)
        IDLE: state_d = SEARCH;
        SEARCH: begin
          if (smp.valid) begin
            x_filt_d = smp.x;
            lost_d   = '0;
            state_d  = smp.near ? STOP : TRACK;
          end
        end
        TRACK, STOP: begin
          if (smp.valid) begin
            x_filt_d = x_iir_c[XF_W-1:0];
            lost_d   = '0;
            state_d  = smp.near ? STOP : TRACK;
          end else if (lost_cnt == LOST_W'(LOST_FRAMES - 1)) begin
            lost_d  = '0;
            state_d = SEARCH;
          end else begin
            lost_d = lost_cnt + LOST_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign err_c  = xf_s - signed'(ERR_W'(H_CENTER));
  assign adj_c  = err_c >>> KP_SHIFT;
  assign base_c = signed'(ERR_W'(BASE_DUTY));

  // Motor command from the settled state; steering is proportional to offset.
  always_comb begin
    duty_l_c = '0;
    duty_r_c = '0;
    dir_l_c  = 1'b1;
    dir_r_c  = 1'b1;
    case (state_q)
      SEARCH: begin
        duty_l_c = DUTY_W'(SEARCH_DUTY);
        duty_r_c = DUTY_W'(SEARCH_DUTY);
        dir_r_c  = 1'b0;
      end
      TRACK: begin
        duty_l_c = sat_add(base_c, adj_c);
        duty_r_c = sat_add(base_c, -adj_c);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      duty_l    <= '0;
      duty_r    <= '0;
      dir_left  <= 1'b0;
      dir_right <= 1'b0;
    end else begin
      duty_l    <= duty_l_c;
      duty_r    <= duty_r_c;
      dir_left  <= dir_l_c;
      dir_right <= dir_r_c;
    end
  end

  motor_pwm #(.PWM_DIV(PWM_DIV)) u_pwm_left (
    .clk    (clk),
    .rst_in (rst_in),
    .duty   (duty_l),
    .pwm    (pwm_left)
  );

  motor_pwm #(.PWM_DIV(PWM_DIV)) u_pwm_right (
    .clk    (clk),
    .rst_in (rst_in),
    .duty   (duty_r),
    .pwm    (pwm_right)
  );

endmodule

// File: tb/tb_chase_steer_ctrl.sv
// Scoreboard bench for chase_steer_ctrl: a frame-level reference model predicts
// state/duty/direction per frame, a monitor checks them after each frame_stb.
module tb_chase_steer_ctrl;

  localparam int unsigned PWM_DIV = 2;
  localparam int PERIOD = 256 * PWM_DIV;
  localparam int M_IDLE = 0, M_SEARCH = 1, M_TRACK = 2, M_STOP = 3;

  logic        clk = 1'b0;
  logic        rst_in, en, vsync;
  logic [31:0] x_center;
  logic [23:0] radius;
  logic        pwm_left, pwm_right, dir_left, dir_right, frame_stb;
  logic [1:0]  state;

  always #5 clk = ~clk;

  chase_steer_ctrl #(.PWM_DIV(PWM_DIV)) dut (
    .clk       (clk),
    .rst_in    (rst_in),
    .en        (en),
    .vsync     (vsync),
    .x_center  (x_center),
    .radius    (radius),
    .pwm_left  (pwm_left),
    .pwm_right (pwm_right),
    .dir_left  (dir_left),
    .dir_right (dir_right),
    .state     (state),
    .frame_stb (frame_stb)
  );

  typedef struct packed {
    logic [1:0] st;
    logic [7:0] dl;
    logic [7:0] dr;
    logic       dirl;
    logic       dirr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_state = M_IDLE;
  int   m_xf = 512;
  int   m_lost = 0;
  int   w1, w2, hl, hr;
  bit   ok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Floor division by 2**s, i.e. the meaning of an arithmetic right shift.
  function automatic int fdiv(input int d, input int s);
    int p;
    p = 1 << s;
    if (d >= 0) return d / p;
    return -((-d + p - 1) / p);
  endfunction

  function automatic int clamp255(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic exp_t expect_cmd();
    exp_t e;
    int   adj;
    e.st = 2'(m_state);
    e.dl = 8'd0; e.dr = 8'd0; e.dirl = 1'b1; e.dirr = 1'b1;
    if (m_state == M_SEARCH) begin
      e.dl = 8'd80; e.dr = 8'd80; e.dirr = 1'b0;
    end else if (m_state == M_TRACK) begin
      adj  = fdiv(m_xf - 512, 1);
      e.dl = 8'(clamp255(128 + adj));
      e.dr = 8'(clamp255(128 - adj));
    end
    return e;
  endfunction

  task automatic model_frame(input logic [31:0] x, input logic [23:0] r);
    bit valid, near;
    valid = (r >= 24'd4) && (x < 32'd1024);
    near  = (r >= 24'd60);
    case (m_state)
      M_IDLE: m_state = M_SEARCH;
      M_SEARCH: if (valid) begin
        m_xf = int'(x); m_lost = 0;
        m_state = near ? M_STOP : M_TRACK;
      end
      default: if (valid) begin
        m_xf = m_xf + fdiv(int'(x) - m_xf, 1); m_lost = 0;
        m_state = near ? M_STOP : M_TRACK;
      end else begin
        m_lost++;
        if (m_lost == 8) begin m_lost = 0; m_state = M_SEARCH; end
      end
    endcase
  endtask

  task automatic send_frame(input logic [31:0] x, input logic [23:0] r);
    @(posedge clk); #1 vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    x_center = x; radius = r; vsync = 1'b0;
    if (en) model_frame(x, r);
    exp_q.push_back(expect_cmd());
    repeat (6) @(posedge clk);
  endtask

  task automatic count_high(output int l, output int r);
    l = 0; r = 0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      if (pwm_left) l++;
      if (pwm_right) r++;
    end
  endtask

  task automatic wait_rise(output bit found);
    logic prev;
    found = 1'b0;
    @(negedge clk); prev = pwm_left;
    for (int i = 0; i < 4 * PERIOD; i++) begin
      @(negedge clk);
      if (pwm_left && !prev) begin found = 1'b1; break; end
      prev = pwm_left;
    end
  endtask

  task automatic high_width(output int w);
    w = 1;
    for (int i = 0; i < 4 * PERIOD && pwm_left; i++) begin
      @(negedge clk);
      if (pwm_left) w++;
    end
  endtask

  // Monitor: two cycles after each frame strobe the duty registers have settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_stb === 1'b1) begin
        @(negedge clk); @(negedge clk);
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("state", 32'(state), 32'(e.st));
          chk("duty_l", 32'(dut.duty_l), 32'(e.dl));
          chk("duty_r", 32'(dut.duty_r), 32'(e.dr));
          chk("dir_left", 32'(dir_left), 32'(e.dirl));
          chk("dir_right", 32'(dir_right), 32'(e.dirr));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] x;
    logic [23:0] r;
    rst_in = 1'b1; en = 1'b0; vsync = 1'b0; x_center = '0; radius = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pwm", 32'({pwm_left, pwm_right}), 32'd0);
    chk("rst_dir", 32'({dir_left, dir_right}), 32'd0);
    chk("rst_stb", 32'(frame_stb), 32'd0);
    rst_in = 1'b0; en = 1'b1;
    repeat (2) @(posedge clk);

    send_frame(32'd512, 24'd20);
    send_frame(32'd512, 24'd20);
    send_frame(32'd640, 24'd20);
    for (int i = 0; i < 8; i++) send_frame(32'd512, 24'd0);
    send_frame(32'd640, 24'd20);
    for (int i = 0; i < 8; i++) send_frame((i % 2 == 0) ? 32'd1024 : 32'h0001_0200, 24'd20);
    send_frame(32'd512, 24'd20);
    send_frame(32'd1000, 24'd20);
    for (int i = 0; i < 8; i++) send_frame(32'd700, 24'd3);
    send_frame(32'd1000, 24'd20);

    // Saturated 255/0 duties seen on the pins.
    repeat (2 * PERIOD) @(posedge clk);
    count_high(hl, hr);
    chk("pwm_sat_left", 32'(hl), 32'(255 * PWM_DIV));
    chk("pwm_sat_right", 32'(hr), 32'd0);

    // Duty change mid-period only takes effect at the next wrap.
    wait_rise(ok);
    chk("pwm_rise_a", 32'(ok), 32'd1);
    fork
      high_width(w1);
      begin repeat (100) @(negedge clk); send_frame(32'd0, 24'd20); end
    join
    chk("width_old", 32'(w1), 32'(255 * PWM_DIV));
    wait_rise(ok);
    chk("pwm_rise_b", 32'(ok), 32'd1);
    high_width(w2);
    chk("width_new", 32'(w2), 32'(122 * PWM_DIV));

    // en low drops to IDLE without a frame.
    en = 1'b0;
    @(posedge clk); #1;
    chk("en_low_state", 32'(state), 32'd0);
    repeat (2) @(posedge clk); #1;
    chk("en_low_duty", 32'({dut.duty_l, dut.duty_r}), 32'd0);
    chk("en_low_dir", 32'({dir_left, dir_right}), 32'd3);
    m_state = M_IDLE; m_lost = 0;
    en = 1'b1;

    send_frame(32'd512, 24'd20);
    send_frame(32'd512, 24'd60);
    repeat (PERIOD + 8) @(posedge clk);
    count_high(hl, hr);
    chk("stop_pwm_left", 32'(hl), 32'd0);
    chk("stop_pwm_right", 32'(hr), 32'd0);
    send_frame(32'd300, 24'd80);
    send_frame(32'd300, 24'd30);

    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 7))
        0: r = 24'd0;
        1: r = 24'd3;
        2: r = 24'd4;
        3: r = 24'd59;
        4: r = 24'd60;
        5: r = 24'hFFFFFF;
        6: r = 24'($urandom_range(61, 200));
        default: r = 24'($urandom_range(5, 58));
      endcase
      case ($urandom_range(0, 6))
        0: x = 32'd1023;
        1: x = 32'd1024;
        2: x = $urandom | 32'h0000_0400;
        3: x = 32'd0;
        default: x = 32'($urandom_range(0, 1023));
      endcase
      send_frame(x, r);
      if ($urandom_range(0, 9) == 0)
        for (int j = 0; j < 9; j++) send_frame(32'($urandom_range(0, 1023)), 24'd1);
    end

    // Async reset while the left pin is high.
    send_frame(32'd512, 24'd20);
    send_frame(32'd512, 24'd20);
    send_frame(32'd512, 24'd20);
    ok = 1'b0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      if (pwm_left) begin ok = 1'b1; break; end
    end
    chk("pwm_high_before_rst", 32'(ok), 32'd1);
    #1 rst_in = 1'b1;
    #1;
    chk("rst_async_pwm", 32'(pwm_left), 32'd0);
    chk("rst_async_state", 32'(state), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chase_steer_ctrl.md
Name: chase_steer_ctrl

Overview:
- Downstream consumer of the colour tracker's per-frame blob centroid and radius.
- Once per video frame (vsync falling edge) it samples x_center/radius, validates and smooths the target position, and runs a search/track/stop state machine.
- Drives two differential-drive motor channels (PWM + direction) that steer the bot toward the blob and halt when close.
- Sits between the tracker and the motor driver pins, in the 65 MHz pixel clock domain.

Parameters:
- H_ACTIVE, 1024, active width; x_center >= H_ACTIVE is invalid.
- H_CENTER, 512, x position meaning "straight ahead".
- MIN_RADIUS, 4, radius below this is "no target".
- STOP_RADIUS, 60, radius at or above this means target reached.
- BASE_DUTY, 128, forward duty while tracking (0..255).
- SEARCH_DUTY, 80, spin-in-place duty while searching.
- KP_SHIFT, 1, steering gain as a right shift of the position error.
- ALPHA_SHIFT, 1, IIR smoothing shift.
- LOST_FRAMES, 8, consecutive invalid frames before returning to SEARCH.
- PWM_DIV, 254, clocks per PWM counter step.

Ports:
- clk  in  1  pixel clock (65 MHz).
- rst_in  in  1  asynchronous, active-high reset.
- en  in  1  run enable; low forces IDLE.
- vsync  in  1  frame sync, same signal fed to the tracker.
- x_center  in  32  blob x mean from the tracker.
- radius  in  24  blob radius from the tracker.
- pwm_left  out  1  left motor PWM.
- pwm_right  out  1  right motor PWM.
- dir_left  out  1  left direction; 1 = forward.
- dir_right  out  1  right direction; 1 = forward.
- state  out  2  FSM state: IDLE=0, SEARCH=1, TRACK=2, STOP=3.
- frame_stb  out  1  one-cycle pulse when a frame sample is taken.

Behaviour:

Reset:
- Reset is asynchronous, active-high, single clock clk.
- Reset values: state=IDLE, all outputs 0, duty registers 0, x_filt=H_CENTER, lost_cnt=0, PWM counters 0.
- Reset asserted mid-period drops pwm_* to 0 immediately.

Frame sampling:
- vsync is registered once; a falling edge (prev=1, now=0) asserts frame_stb in the following cycle.
- In that same cycle, x_center and radius are latched.
- valid = (radius >= MIN_RADIUS) && (x_center < H_ACTIVE). Compare on full width, so upper bits set means invalid.

FSM (evaluated only on frame_stb, except en):
- en low: go to IDLE asynchronously-to-frame (next clk); duties 0.
- IDLE -> SEARCH on first frame_stb with en=1.
- SEARCH, valid:
  - Load x_filt = x_center[10:0] directly (no smoothing) and clear lost_cnt.
  - Go to STOP if radius >= STOP_RADIUS, else TRACK.
- TRACK, valid:
  - x_filt <= x_filt + ((x - x_filt) >>> ALPHA_SHIFT), signed 12-bit arithmetic.
  - lost_cnt=0.
  - Go to STOP if radius >= STOP_RADIUS.
- TRACK, invalid:
  - lost_cnt++ and hold previous duties.
  - When lost_cnt reaches LOST_FRAMES -> SEARCH, lost_cnt=0.
- STOP:
  - Stays while valid and radius >= STOP_RADIUS.
  - Valid but smaller radius -> TRACK.
  - Invalid frames count as in TRACK, then go to SEARCH.

Commands (registered on the cycle after the state update):
- IDLE/STOP: duty_l = duty_r = 0; dir both 1.
- SEARCH: duty both = SEARCH_DUTY; dir_left=1, dir_right=0 (spin clockwise).
- TRACK:
  - err = x_filt - H_CENTER (signed 12b); adj = err >>> KP_SHIFT.
  - duty_l = sat(BASE_DUTY + adj), duty_r = sat(BASE_DUTY - adj), saturating to 0..255.
  - dir both 1.

PWM:
- Prescaler counts 0..PWM_DIV-1; each wrap increments an 8-bit counter pc.
- pwm_x = (pc < active_duty_x).
- active_duty is copied from the duty register only when pc wraps 255->0 (glitch-free); duty 0 gives a constant low output.
- Latency: frame_stb to new duty register is 2 clk; to the PWM pin is up to one PWM period.

Decomposition:
- Package chase_pkg: state enum (IDLE, SEARCH, TRACK, STOP), duty width constant (8), and the saturating add helper function.
- One sub-module, motor_pwm: prescaler + 8-bit counter + wrap-synchronised duty update.
- Instantiate motor_pwm twice (left, right).

Test Plan:
- Reset, en=1, one vsync fall with x=512, r=20:
  - Expect state IDLE->SEARCH.
  - Next fall: state TRACK, duty_l=duty_r=128.
- From SEARCH, frame x=640, r=20 -> x_filt=640, duty_l=192, duty_r=64.
- In TRACK with x_filt=512, frame x=640 -> x_filt=576, duty_l=160, duty_r=96.
- In TRACK, frame x=1000 -> x_filt=756, adj=122, duty_l=250, duty_r=6.
- From SEARCH (direct load), frame x=1000 -> adj=244, duty_l saturates to 255, duty_r saturates to 0.
- In TRACK, 7 frames r=0 -> still TRACK, duties held; 8th -> SEARCH, duty 80/80, dir_right=0.
- Frame r=60 -> STOP, pwm both low within one PWM period.
- Change duty mid-period: pwm width changes only after pc wraps.
- Assert rst_in while pwm_left=1 -> pwm_left=0 the same instant, state=IDLE.
